// File: rtl/stack_row_engine_pkg.sv
// Shared types and constants for the stacker game row writer.
package stack_row_engine_pkg;

    localparam int unsigned ROW_W     = 8;
    localparam int unsigned ROW_IDX_W = 3;
    localparam int unsigned STATE_W   = 3;

    localparam logic [ROW_IDX_W-1:0] LAST_ROW = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SLIDE   = 3'd2,
        ST_DROP    = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_LOSE    = 3'd5,
        ST_WIN     = 3'd7
    } state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

endpackage

// File: rtl/stack_row_shifter.sv
// One bounce step of the sliding segment; a full row cannot move.
module stack_row_shifter
    import stack_row_engine_pkg::*;
(
    input  logic [ROW_W-1:0] pattern,
    input  dir_t             dir,
    output logic [ROW_W-1:0] next_pattern_c,
    output dir_t             next_dir_c,
    output logic             moved_c
);

    always_comb begin
        next_pattern_c = pattern;
        next_dir_c     = dir;
        moved_c        = 1'b0;
        if (!(pattern[ROW_W-1] && pattern[0])) begin
            moved_c = 1'b1;
            if (dir == DIR_RIGHT) begin
                if (!pattern[0]) begin
                    next_pattern_c = pattern >> 1;
                end else begin
                    next_pattern_c = pattern << 1;
                    next_dir_c     = DIR_LEFT;
                end
            end else begin
                if (!pattern[ROW_W-1]) begin
                    next_pattern_c = pattern << 1;
                end else begin
                    next_pattern_c = pattern >> 1;
                    next_dir_c     = DIR_RIGHT;
                end
            end
        end
    end

endmodule

// File: rtl/stack_row_engine.sv
// Stacker game FSM: slides a segment, drops it onto the row below and
// emits registered row writes, array clears and the game state.
module stack_row_engine
    import stack_row_engine_pkg::*;
#(
    parameter int unsigned INIT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn,
    input  logic                 updateClk,
    output logic [ROW_W-1:0]     val,
    output logic [ROW_IDX_W-1:0] rowIndex,
    output logic                 writeStrobe,
    output logic                 clrarray,
    output logic [STATE_W-1:0]   state
);

    localparam logic [ROW_W-1:0] INIT_PATTERN = ~({ROW_W{1'b1}} >> INIT_WIDTH);

    state_t               state_q, state_d;
    logic [ROW_W-1:0]     val_q, val_d;
    logic [ROW_IDX_W-1:0] row_q, row_d;
    logic                 strobe_q, strobe_d;
    logic                 clr_q, clr_d;
    logic [ROW_W-1:0]     pattern_q, pattern_d;
    logic [ROW_W-1:0]     prev_q, prev_d;
    dir_t                 dir_q, dir_d;

    logic [ROW_W-1:0]     shift_pattern_c;
    dir_t                 shift_dir_c;
    logic                 shift_moved_c;
    logic [ROW_W-1:0]     landed_c;
    logic                 start_game_c;

    stack_row_shifter u_shifter (
        .pattern        (pattern_q),
        .dir            (dir_q),
        .next_pattern_c (shift_pattern_c),
        .next_dir_c     (shift_dir_c),
        .moved_c        (shift_moved_c)
    );

    assign landed_c = pattern_q & prev_q;

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        val_d        = val_q;
        row_d        = row_q;
        strobe_d     = 1'b0;
        clr_d        = 1'b0;
        pattern_d    = pattern_q;
        prev_d       = prev_q;
        dir_d        = dir_q;
        start_game_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn) start_game_c = 1'b1;
            end
            ST_CLEAR: begin
                state_d = ST_SLIDE;
            end
            ST_SLIDE: begin
                if (btn) begin
                    state_d = ST_DROP;
                end else if (updateClk && shift_moved_c) begin
                    pattern_d = shift_pattern_c;
                    dir_d     = shift_dir_c;
                    val_d     = shift_pattern_c;
                    strobe_d  = 1'b1;
                end
            end
            ST_DROP: begin
                strobe_d = 1'b1;
                if (landed_c == '0) begin
                    val_d   = '0;
                    state_d = ST_LOSE;
                end else begin
                    val_d     = landed_c;
                    prev_d    = landed_c;
                    pattern_d = landed_c;
                    state_d   = (row_q == LAST_ROW) ? ST_WIN : ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                row_d    = row_q + 3'd1;
                val_d    = pattern_q;
                strobe_d = 1'b1;
                state_d  = ST_SLIDE;
            end
            ST_LOSE, ST_WIN: begin
                if (btn) start_game_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear is issued on the entry edge so it is high while in CLEAR.
        if (start_game_c) begin
            state_d   = ST_CLEAR;
            clr_d     = 1'b1;
            row_d     = '0;
            prev_d    = {ROW_W{1'b1}};
            dir_d     = DIR_RIGHT;
            pattern_d = INIT_PATTERN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            val_q     <= '0;
            row_q     <= '0;
            strobe_q  <= 1'b0;
            clr_q     <= 1'b0;
            pattern_q <= '0;
            prev_q    <= {ROW_W{1'b1}};
            dir_q     <= DIR_RIGHT;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            row_q     <= row_d;
            strobe_q  <= strobe_d;
            clr_q     <= clr_d;
            pattern_q <= pattern_d;
            prev_q    <= prev_d;
            dir_q     <= dir_d;
        end
    end

    assign val         = val_q;
    assign rowIndex    = row_q;
    assign writeStrobe = strobe_q;
    assign clrarray    = clr_q;
    assign state       = state_q;

endmodule
